// File: rtl/brush_write_arbiter.sv
// Shares the simulation-RAM write port between the next-state engine (absolute priority)
// and a paint brush that expands each accepted stroke into a clipped BRUSH_SIZE x BRUSH_SIZE square.
module brush_write_arbiter #(
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS),
  parameter int DATA_WIDTH     = 1,
  parameter int BRUSH_SIZE     = 4,
  parameter int X_WIDTH        = $clog2(ACTIVE_COLUMNS),
  parameter int Y_WIDTH        = $clog2(ACTIVE_ROWS)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  sim_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] sim_wr_address_i,
  input  logic [DATA_WIDTH-1:0] sim_wr_data_i,
  input  logic                  draw_en_i,
  input  logic                  brush_valid_i,
  output logic                  brush_ready_o,
  input  logic [X_WIDTH-1:0]    brush_x_i,
  input  logic [Y_WIDTH-1:0]    brush_y_i,
  input  logic [DATA_WIDTH-1:0] brush_data_i,
  output logic                  ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_address_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  output logic                  stroke_done_o
);

  localparam int BW = (BRUSH_SIZE > 1) ? $clog2(BRUSH_SIZE) : 1;
  localparam logic [BW-1:0]        LAST_D = BW'(BRUSH_SIZE - 1);
  localparam logic [X_WIDTH:0]     COLS_X = (X_WIDTH+1)'(ACTIVE_COLUMNS);
  localparam logic [Y_WIDTH:0]     ROWS_Y = (Y_WIDTH+1)'(ACTIVE_ROWS);
  localparam logic [ADDR_WIDTH-1:0] COLS_A = ADDR_WIDTH'(ACTIVE_COLUMNS);

  typedef enum logic {IDLE, PAINT} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [X_WIDTH-1:0]    r_x;
  logic [Y_WIDTH-1:0]    r_y;
  logic [DATA_WIDTH-1:0] r_data;
  logic [BW-1:0]         r_dx;
  logic [BW-1:0]         r_dy;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_address;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_process;
  logic                  w_last;
  logic                  w_in_bounds;
  logic                  w_brush_wr;
  logic                  w_done;
  logic [X_WIDTH:0]      w_px;
  logic [Y_WIDTH:0]      w_py;
  logic [ADDR_WIDTH-1:0] w_brush_addr;

  assign brush_ready_o = (r_state == IDLE) & draw_en_i;
  assign w_accept      = brush_valid_i & brush_ready_o;

  // Pixel coordinates carry one extra bit so clipping at the frame edge cannot wrap.
  assign w_px         = {1'b0, r_x} + (X_WIDTH+1)'(r_dx);
  assign w_py         = {1'b0, r_y} + (Y_WIDTH+1)'(r_dy);
  assign w_in_bounds  = (w_px < COLS_X) && (w_py < ROWS_Y);
  assign w_brush_addr = ADDR_WIDTH'(w_py) * COLS_A + ADDR_WIDTH'(w_px);

  assign w_process  = (r_state == PAINT) && !sim_wr_en_i;
  assign w_last     = (r_dx == LAST_D) && (r_dy == LAST_D);
  assign w_brush_wr = w_process && w_in_bounds;
  assign w_done     = w_process && w_last;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = PAINT;
      PAINT:   if (w_done)   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_x    <= '0;
      r_y    <= '0;
      r_data <= '0;
      r_dx   <= '0;
      r_dy   <= '0;
    end else if (w_accept) begin
      r_x    <= brush_x_i;
      r_y    <= brush_y_i;
      r_data <= brush_data_i;
      r_dx   <= '0;
      r_dy   <= '0;
    end else if (w_process) begin
      if (r_dx == LAST_D) begin
        r_dx <= '0;
        r_dy <= r_dy + 1'b1;
      end else begin
        r_dx <= r_dx + 1'b1;
      end
    end
  end

  // Output register: a sim write always wins the port; the brush only writes in its idle slots.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_en      <= 1'b0;
      r_wr_address <= '0;
      r_wr_data    <= '0;
      r_done       <= 1'b0;
    end else begin
      r_wr_en <= sim_wr_en_i | w_brush_wr;
      r_done  <= w_done;
      if (sim_wr_en_i) begin
        r_wr_address <= sim_wr_address_i;
        r_wr_data    <= sim_wr_data_i;
      end else if (w_brush_wr) begin
        r_wr_address <= w_brush_addr;
        r_wr_data    <= r_data;
      end
    end
  end

  assign ram_wr_en_o      = r_wr_en;
  assign ram_wr_address_o = r_wr_address;
  assign ram_wr_data_o    = r_wr_data;
  assign stroke_done_o    = r_done;

endmodule

// File: tb/tb_brush_write_arbiter.sv
// Directed bench for brush_write_arbiter: reset, passthrough, strokes, contention, clipping, abort.
module tb_brush_write_arbiter;
  localparam int COLS = 640;
  localparam int ROWS = 480;
  localparam int AW   = 19;
  localparam int XW   = 10;
  localparam int YW   = 9;
  localparam int BS   = 4;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          sim_wr_en_i;
  logic [AW-1:0] sim_wr_address_i;
  logic          sim_wr_data_i;
  logic          draw_en_i;
  logic          brush_valid_i;
  logic          brush_ready_o;
  logic [XW-1:0] brush_x_i;
  logic [YW-1:0] brush_y_i;
  logic          brush_data_i;
  logic          ram_wr_en_o;
  logic [AW-1:0] ram_wr_address_o;
  logic          ram_wr_data_o;
  logic          stroke_done_o;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] wr_addr [0:63];
  logic          wr_data [0:63];
  int            wr_cyc  [0:63];
  logic          rdy_at  [0:63];
  int            wr_n;
  int            done_n;
  int            done_cyc;

  always #5 clk_i = ~clk_i;

  brush_write_arbiter #(
    .ACTIVE_COLUMNS(COLS), .ACTIVE_ROWS(ROWS), .ADDR_WIDTH(AW), .DATA_WIDTH(1),
    .BRUSH_SIZE(BS), .X_WIDTH(XW), .Y_WIDTH(YW)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .sim_wr_en_i(sim_wr_en_i), .sim_wr_address_i(sim_wr_address_i), .sim_wr_data_i(sim_wr_data_i),
    .draw_en_i(draw_en_i), .brush_valid_i(brush_valid_i), .brush_ready_o(brush_ready_o),
    .brush_x_i(brush_x_i), .brush_y_i(brush_y_i), .brush_data_i(brush_data_i),
    .ram_wr_en_o(ram_wr_en_o), .ram_wr_address_o(ram_wr_address_o), .ram_wr_data_o(ram_wr_data_o),
    .stroke_done_o(stroke_done_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_stroke(input int x, input int y, input logic d);
    brush_x_i     = XW'(x);
    brush_y_i     = YW'(y);
    brush_data_i  = d;
    brush_valid_i = 1'b1;
  endtask

  // Runs n cycles after the current one (cycle k = T+k), logging writes, done pulses and ready.
  task automatic run_cycles(input int n, input int sim_start, input int sim_len,
                            input logic [AW-1:0] sim_addr, input int draw_drop);
    wr_n = 0; done_n = 0; done_cyc = -1;
    for (int k = 1; k <= n; k++) begin
      step();
      if (ram_wr_en_o && wr_n < 64) begin
        wr_addr[wr_n] = ram_wr_address_o;
        wr_data[wr_n] = ram_wr_data_o;
        wr_cyc[wr_n]  = k;
        wr_n++;
      end
      if (stroke_done_o) begin done_n++; done_cyc = k; end
      if (k < 64) rdy_at[k] = brush_ready_o;
      brush_valid_i    = 1'b0;
      if (draw_drop > 0 && k == draw_drop) draw_en_i = 1'b0;
      sim_wr_en_i      = (k >= sim_start) && (k < sim_start + sim_len);
      sim_wr_address_i = sim_addr;
    end
    sim_wr_en_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; sim_wr_en_i = 0; sim_wr_address_i = '0; sim_wr_data_i = 0;
    draw_en_i = 0; brush_valid_i = 0; brush_x_i = '0; brush_y_i = '0; brush_data_i = 0;
    step(); step();
    checks++; if (ram_wr_en_o !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%0b want=0", ram_wr_en_o); end
    checks++; if (ram_wr_address_o !== '0) begin errors++; $display("FAIL reset_addr got=%0d want=0", ram_wr_address_o); end
    checks++; if (stroke_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b want=0", stroke_done_o); end
    checks++; if (brush_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_de0 got=%0b want=0", brush_ready_o); end
    draw_en_i = 1; #1;
    checks++; if (brush_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_de1 got=%0b want=1", brush_ready_o); end
    reset_i = 0;
    step();
  endtask

  task automatic test_sim_passthrough();
    sim_wr_en_i = 1; sim_wr_address_i = AW'(123); sim_wr_data_i = 1;
    step();
    sim_wr_en_i = 0; sim_wr_data_i = 0;
    checks++; if (ram_wr_en_o !== 1'b1 || ram_wr_address_o !== AW'(123) || ram_wr_data_o !== 1'b1) begin
      errors++; $display("FAIL sim_pass got=%0b/%0d/%0b want=1/123/1", ram_wr_en_o, ram_wr_address_o, ram_wr_data_o); end
    step();
    checks++; if (ram_wr_en_o !== 1'b0) begin errors++; $display("FAIL sim_pass_idle got=%0b want=0", ram_wr_en_o); end
  endtask

  task automatic test_uncontended();
    int exp;
    start_stroke(10, 20, 1'b1);
    checks++; if (brush_ready_o !== 1'b1) begin errors++; $display("FAIL unc_ready got=%0b want=1", brush_ready_o); end
    run_cycles(20, 0, 0, '0, 0);
    checks++; if (wr_n !== 16) begin errors++; $display("FAIL unc_count got=%0d want=16", wr_n); end
    checks++; if (wr_n > 0 && wr_addr[0] !== AW'(12810)) begin errors++; $display("FAIL unc_first got=%0d want=12810", wr_addr[0]); end
    checks++; if (wr_n > 15 && wr_addr[15] !== AW'(14733)) begin errors++; $display("FAIL unc_last got=%0d want=14733", wr_addr[15]); end
    for (int i = 0; i < 16 && i < wr_n; i++) begin
      exp = (20 + i / 4) * COLS + 10 + i % 4;
      checks++;
      if (wr_addr[i] !== AW'(exp) || wr_cyc[i] !== i + 2 || wr_data[i] !== 1'b1) begin
        errors++; $display("FAIL unc_write%0d got=%0d@%0d d%0b want=%0d@%0d d1", i, wr_addr[i], wr_cyc[i], wr_data[i], exp, i + 2);
      end
    end
    checks++; if (done_n !== 1 || done_cyc !== 17) begin errors++; $display("FAIL unc_done got=%0d@%0d want=1@17", done_n, done_cyc); end
    checks++; if (rdy_at[16] !== 1'b0 || rdy_at[17] !== 1'b1) begin
      errors++; $display("FAIL unc_ready_back got=%0b%0b want=01", rdy_at[16], rdy_at[17]); end
  endtask

  task automatic test_contention();
    int nb, ns, exp;
    nb = 0; ns = 0;
    sim_wr_data_i = 0;
    start_stroke(10, 20, 1'b1);
    run_cycles(22, 3, 2, AW'(5000), 0);
    for (int i = 0; i < wr_n; i++) begin
      if (wr_addr[i] === AW'(5000)) begin
        checks++;
        if (wr_cyc[i] !== 4 + ns || wr_data[i] !== 1'b0) begin
          errors++; $display("FAIL cont_sim%0d got=@%0d d%0b want=@%0d d0", ns, wr_cyc[i], wr_data[i], 4 + ns);
        end
        ns++;
      end else begin
        exp = (20 + nb / 4) * COLS + 10 + nb % 4;
        checks++;
        if (wr_addr[i] !== AW'(exp)) begin errors++; $display("FAIL cont_brush%0d got=%0d want=%0d", nb, wr_addr[i], exp); end
        nb++;
      end
    end
    checks++; if (ns !== 2) begin errors++; $display("FAIL cont_sim_count got=%0d want=2", ns); end
    checks++; if (nb !== 16) begin errors++; $display("FAIL cont_brush_count got=%0d want=16", nb); end
    checks++; if (done_n !== 1 || done_cyc !== 19) begin errors++; $display("FAIL cont_done got=%0d@%0d want=1@19", done_n, done_cyc); end
  endtask

  task automatic test_clipping();
    logic [AW-1:0] ea [0:3];
    int            ec [0:3];
    ea[0] = AW'(306558); ea[1] = AW'(306559); ea[2] = AW'(307198); ea[3] = AW'(307199);
    ec[0] = 2; ec[1] = 3; ec[2] = 6; ec[3] = 7;
    start_stroke(638, 478, 1'b0);
    run_cycles(20, 0, 0, '0, 0);
    checks++; if (wr_n !== 4) begin errors++; $display("FAIL clip_count got=%0d want=4", wr_n); end
    for (int i = 0; i < 4 && i < wr_n; i++) begin
      checks++;
      if (wr_addr[i] !== ea[i] || wr_cyc[i] !== ec[i] || wr_data[i] !== 1'b0) begin
        errors++; $display("FAIL clip_write%0d got=%0d@%0d d%0b want=%0d@%0d d0", i, wr_addr[i], wr_cyc[i], wr_data[i], ea[i], ec[i]);
      end
    end
    checks++; if (done_n !== 1 || done_cyc !== 17) begin errors++; $display("FAIL clip_done got=%0d@%0d want=1@17", done_n, done_cyc); end
  endtask

  task automatic test_draw_enable();
    draw_en_i = 0;
    start_stroke(100, 100, 1'b1);
    #1;
    checks++; if (brush_ready_o !== 1'b0) begin errors++; $display("FAIL de_ready got=%0b want=0", brush_ready_o); end
    for (int k = 0; k < 10; k++) begin
      step();
      checks++; if (ram_wr_en_o !== 1'b0) begin errors++; $display("FAIL de_nowrite%0d got=%0b want=0", k, ram_wr_en_o); end
    end
    brush_valid_i = 0;
    draw_en_i = 1;
    start_stroke(10, 20, 1'b1);
    run_cycles(20, 0, 0, '0, 5);
    checks++; if (wr_n !== 16) begin errors++; $display("FAIL de_drop_count got=%0d want=16", wr_n); end
    checks++; if (done_n !== 1 || done_cyc !== 17) begin errors++; $display("FAIL de_drop_done got=%0d@%0d want=1@17", done_n, done_cyc); end
    checks++; if (rdy_at[18] !== 1'b0) begin errors++; $display("FAIL de_drop_ready got=%0b want=0", rdy_at[18]); end
    draw_en_i = 1;
  endtask

  task automatic test_reset_abort();
    int exp;
    start_stroke(10, 20, 1'b1);
    run_cycles(8, 0, 0, '0, 0);
    checks++; if (ram_wr_en_o !== 1'b1) begin errors++; $display("FAIL abort_pre got=%0b want=1", ram_wr_en_o); end
    reset_i = 1;
    step();
    checks++; if (ram_wr_en_o !== 1'b0 || ram_wr_address_o !== '0 || stroke_done_o !== 1'b0) begin
      errors++; $display("FAIL abort_outputs got=%0b/%0d/%0b want=0/0/0", ram_wr_en_o, ram_wr_address_o, stroke_done_o); end
    checks++; if (brush_ready_o !== 1'b1) begin errors++; $display("FAIL abort_idle got=%0b want=1", brush_ready_o); end
    reset_i = 0;
    run_cycles(12, 0, 0, '0, 0);
    checks++; if (wr_n !== 0 || done_n !== 0) begin errors++; $display("FAIL abort_quiet got=%0d writes %0d done want=0/0", wr_n, done_n); end
    start_stroke(10, 20, 1'b1);
    run_cycles(20, 0, 0, '0, 0);
    checks++; if (wr_n !== 16) begin errors++; $display("FAIL abort_restart_count got=%0d want=16", wr_n); end
    for (int i = 0; i < 16 && i < wr_n; i++) begin
      exp = (20 + i / 4) * COLS + 10 + i % 4;
      checks++; if (wr_addr[i] !== AW'(exp)) begin errors++; $display("FAIL abort_restart%0d got=%0d want=%0d", i, wr_addr[i], exp); end
    end
    checks++; if (done_n !== 1 || done_cyc !== 17) begin errors++; $display("FAIL abort_restart_done got=%0d@%0d want=1@17", done_n, done_cyc); end
  endtask

  initial begin
    test_reset();
    test_sim_passthrough();
    test_uncontended();
    test_contention();
    test_clipping();
    test_draw_enable();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
